// File: rtl/smart_access_sequencer_if.sv
// rtl/smart_access_sequencer_if.sv - CPU/DMA key-memory bus bundle for the SMART sequencer
interface smart_access_sequencer_if;
    logic [15:0] cpu_addr;
    logic        cpu_en;
    logic [15:0] cpu_dout;
    logic [15:0] dma_addr;
    logic        dma_en;
    logic [15:0] dma_dout;
    logic [15:0] mem_din;

    modport master (
        output cpu_addr, cpu_en, dma_addr, dma_en, mem_din,
        input  cpu_dout, dma_dout
    );

    modport slave (
        input  cpu_addr, cpu_en, dma_addr, dma_en, mem_din,
        output cpu_dout, dma_dout
    );
endinterface

// File: rtl/smart_access_sequencer.sv
// rtl/smart_access_sequencer.sv - SMART protected code/key sequencer with violation reset stretcher
module smart_access_sequencer #(
    parameter logic [15:0] LOW_CODE   = 16'hA000,
    parameter logic [15:0] HIGH_CODE  = 16'hA0FF,
    parameter logic [15:0] LOW_KEY    = 16'h0200,
    parameter logic [15:0] HIGH_KEY   = 16'h021F,
    parameter int          RST_CYCLES = 4
) (
    input  logic                           mclk,
    input  logic                           reset_n,
    input  logic [15:0]                    ins_addr,
    input  logic                           disable_debug,
    smart_access_sequencer_if.slave        bus,
    output logic                           in_safe_area,
    output logic                           sys_rst,
    output logic [1:0]                     viol_cause,
    output logic [7:0]                     viol_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_INSIDE, S_VIOL, S_HOLD} state_t;

    // VIOL supplies one reset cycle, HOLD counts down through the rest
    localparam logic [7:0] HOLD_INIT = 8'(RST_CYCLES - 2);

    state_t      state, state_nxt;
    logic [7:0]  hold_cnt;
    logic        code_hit, entry, cpu_key, dma_key;
    logic        viol_det;
    logic [1:0]  cause_nxt;

    assign code_hit = (ins_addr >= LOW_CODE) && (ins_addr <= HIGH_CODE);
    assign entry    = (ins_addr == LOW_CODE);
    assign cpu_key  = bus.cpu_en && (bus.cpu_addr >= LOW_KEY) && (bus.cpu_addr <= HIGH_KEY);
    assign dma_key  = bus.dma_en && (bus.dma_addr >= LOW_KEY) && (bus.dma_addr <= HIGH_KEY);

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        viol_det     = 1'b0;
        cause_nxt    = 2'd0;
        in_safe_area = (state == S_INSIDE);
        sys_rst      = (state == S_VIOL) || (state == S_HOLD);
        case (state)
            S_IDLE: begin
                if (!disable_debug && (dma_key || (code_hit && !entry) || (cpu_key && !entry))) begin
                    viol_det  = 1'b1;
                    cause_nxt = dma_key ? 2'd3 : ((code_hit && !entry) ? 2'd1 : 2'd2);
                    state_nxt = S_VIOL;
                end else if (entry) begin
                    state_nxt = S_INSIDE;
                end
            end
            S_INSIDE: begin
                if (!disable_debug && dma_key) begin
                    viol_det  = 1'b1;
                    cause_nxt = 2'd3;
                    state_nxt = S_VIOL;
                end else if (!code_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_VIOL: state_nxt = S_HOLD;
            S_HOLD: begin
                if (hold_cnt == 8'd0) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt   <= 8'd0;
            viol_cause <= 2'd0;
            viol_cnt   <= 8'd0;
        end else begin
            if (state == S_VIOL) begin
                hold_cnt <= HOLD_INIT;
            end else if (state == S_HOLD && hold_cnt != 8'd0) begin
                hold_cnt <= hold_cnt - 8'd1;
            end
            if (viol_det) begin
                viol_cause <= cause_nxt;
                if (viol_cnt != 8'hFF) begin
                    viol_cnt <= viol_cnt + 8'd1;
                end
            end
        end
    end

    // Key data reaches the CPU only from inside the protected code (or its entry instruction)
    assign bus.cpu_dout = ((cpu_key && (state == S_INSIDE || (state == S_IDLE && entry))) ||
                           (!cpu_key && !sys_rst)) ? bus.mem_din : 16'h0000;
    assign bus.dma_dout = (dma_key || sys_rst) ? 16'h0000 : bus.mem_din;
endmodule

// File: tb/tb_smart_access_sequencer.sv
// tb/tb_smart_access_sequencer.sv - self-checking bench for smart_access_sequencer
module tb_smart_access_sequencer;
    localparam logic [15:0] LC = 16'hA000;
    localparam logic [15:0] HC = 16'hA0FF;
    localparam logic [15:0] LK = 16'h0200;
    localparam logic [15:0] HK = 16'h021F;
    localparam int          RSTC = 4;

    logic        mclk = 1'b0;
    logic        reset_n;
    logic [15:0] ins_addr;
    logic        disable_debug;
    logic        in_safe_area;
    logic        sys_rst;
    logic [1:0]  viol_cause;
    logic [7:0]  viol_cnt;

    smart_access_sequencer_if bus();

    smart_access_sequencer dut (
        .mclk          (mclk),
        .reset_n       (reset_n),
        .ins_addr      (ins_addr),
        .disable_debug (disable_debug),
        .bus           (bus),
        .in_safe_area  (in_safe_area),
        .sys_rst       (sys_rst),
        .viol_cause    (viol_cause),
        .viol_cnt      (viol_cnt)
    );

    always #5 mclk = ~mclk;

    int checks = 0;
    int errors = 0;

    bit   m_inside;
    int   m_rst_left;
    int   m_cause;
    int   m_cnt;

    function automatic bit in_rng(input logic [15:0] a, input logic [15:0] lo, input logic [15:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_inside   = 1'b0;
        m_rst_left = 0;
        m_cause    = 0;
        m_cnt      = 0;
    endtask

    task automatic check_outputs();
        bit ck, dk, entry, rst, legal;
        logic [15:0] exp_cpu, exp_dma;
        ck    = bus.cpu_en && in_rng(bus.cpu_addr, LK, HK);
        dk    = bus.dma_en && in_rng(bus.dma_addr, LK, HK);
        entry = (ins_addr == LC);
        rst   = (m_rst_left > 0);
        legal = m_inside || (!rst && entry);
        exp_cpu = ((ck && legal) || (!ck && !rst)) ? bus.mem_din : 16'h0000;
        exp_dma = (dk || rst) ? 16'h0000 : bus.mem_din;
        chk("in_safe_area", in_safe_area, m_inside);
        chk("sys_rst", sys_rst, rst);
        chk("viol_cause", viol_cause, m_cause);
        chk("viol_cnt", viol_cnt, m_cnt);
        chk("cpu_dout", bus.cpu_dout, exp_cpu);
        chk("dma_dout", bus.dma_dout, exp_dma);
    endtask

    // Reference: a violation arms RSTC reset cycles; otherwise track inside/outside the code region
    task automatic model_edge();
        bit ck, dk, code, entry;
        int c;
        ck    = bus.cpu_en && in_rng(bus.cpu_addr, LK, HK);
        dk    = bus.dma_en && in_rng(bus.dma_addr, LK, HK);
        code  = in_rng(ins_addr, LC, HC);
        entry = (ins_addr == LC);
        if (m_rst_left > 0) begin
            m_rst_left--;
        end else begin
            c = 0;
            if (!disable_debug) begin
                if (dk) c = 3;
                else if (!m_inside && code && !entry) c = 1;
                else if (!m_inside && ck && !entry) c = 2;
            end
            if (c != 0) begin
                m_cause    = c;
                m_cnt      = (m_cnt < 255) ? m_cnt + 1 : 255;
                m_rst_left = RSTC;
                m_inside   = 1'b0;
            end else if (!m_inside && entry) begin
                m_inside = 1'b1;
            end else if (m_inside && !code) begin
                m_inside = 1'b0;
            end
        end
    endtask

    task automatic step(input logic [15:0] ia, input logic [15:0] ca, input logic ce,
                        input logic [15:0] da, input logic de, input logic [15:0] din,
                        input logic dd);
        ins_addr      = ia;
        bus.cpu_addr  = ca;
        bus.cpu_en    = ce;
        bus.dma_addr  = da;
        bus.dma_en    = de;
        bus.mem_din   = din;
        disable_debug = dd;
        #1;
        check_outputs();
        @(posedge mclk);
        model_edge();
        #1;
    endtask

    task automatic idle_step();
        step(16'h4000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'(($urandom)), 1'b0);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (m_rst_left > 0 && guard < 20) begin
            idle_step();
            guard++;
        end
        chk("wait_idle_sys_rst", sys_rst, 0);
    endtask

    function automatic logic [15:0] pick_ins();
        case ($urandom_range(0, 8))
            0: return 16'h4000;
            1: return LC - 16'd1;
            2, 3, 4: return LC;
            5: return HC;
            6: return HC + 16'd1;
            7: return 16'hA080;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [15:0] pick_key();
        case ($urandom_range(0, 5))
            0: return LK - 16'd1;
            1: return LK;
            2: return HK;
            3: return HK + 16'd1;
            4: return 16'h0210;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        reset_n       = 1'b0;
        ins_addr      = 16'h4000;
        disable_debug = 1'b0;
        bus.cpu_addr  = 16'h0000;
        bus.cpu_en    = 1'b0;
        bus.dma_addr  = 16'h0000;
        bus.dma_en    = 1'b0;
        bus.mem_din   = 16'h0000;
        model_reset();
        repeat (2) @(posedge mclk);
        #1;
        chk("reset_in_safe", in_safe_area, 0);
        chk("reset_sys_rst", sys_rst, 0);
        chk("reset_cause", viol_cause, 0);
        chk("reset_cnt", viol_cnt, 0);
        reset_n = 1'b1;
        @(posedge mclk);
        #1;

        // legal entry and exit
        step(16'h9FFE, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h1111, 1'b0);
        step(16'hA000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h1111, 1'b0);
        chk("entry_in_safe", in_safe_area, 1);
        step(16'hA010, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h1111, 1'b0);
        step(16'hB000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h1111, 1'b0);
        chk("exit_in_safe", in_safe_area, 0);
        chk("exit_sys_rst", sys_rst, 0);

        // bad entry
        step(16'hA004, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h2222, 1'b0);
        chk("bad_entry_sys_rst", sys_rst, 1);
        chk("bad_entry_cause", viol_cause, 1);
        chk("bad_entry_cnt", viol_cnt, 1);
        wait_idle();

        // CPU key access from outside, then from inside
        step(16'h4000, 16'h0210, 1'b1, 16'h0000, 1'b0, 16'h5A5A, 1'b0);
        chk("outside_key_cause", viol_cause, 2);
        wait_idle();
        step(16'hA000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h5A5A, 1'b0);
        step(16'hA010, 16'h0210, 1'b1, 16'h0000, 1'b0, 16'h5A5A, 1'b0);
        chk("inside_key_dout", bus.cpu_dout, 16'h5A5A);
        chk("inside_key_sys_rst", sys_rst, 0);
        chk("inside_key_cnt", viol_cnt, 2);
        step(16'h4000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h5A5A, 1'b0);

        // DMA priority over bad entry, and masking during HOLD
        step(16'hA004, 16'h0000, 1'b0, 16'h0205, 1'b1, 16'h3333, 1'b0);
        chk("dma_priority_cause", viol_cause, 3);
        step(16'h4000, 16'h0210, 1'b1, 16'h0000, 1'b0, 16'h3333, 1'b0);
        step(16'h4000, 16'h0210, 1'b1, 16'h0000, 1'b0, 16'h3333, 1'b0);
        chk("hold_mask_cnt", viol_cnt, 3);
        chk("hold_mask_cause", viol_cause, 3);
        wait_idle();

        // debug disable suppresses detection
        step(16'hA004, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h4444, 1'b1);
        chk("debug_sys_rst", sys_rst, 0);
        chk("debug_cnt", viol_cnt, 3);
        step(16'h4000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h4444, 1'b1);

        // randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            step(pick_ins(), pick_key(), ($urandom_range(0, 2) == 0),
                 pick_key(), ($urandom_range(0, 5) == 0), 16'($urandom),
                 ($urandom_range(0, 7) == 0));
        end
        wait_idle();

        // saturation
        for (int i = 0; i < 260; i++) begin
            step(16'hA004, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'($urandom), 1'b0);
            wait_idle();
        end
        chk("saturate_cnt", viol_cnt, 255);

        // asynchronous reset in the second HOLD cycle
        step(16'hA004, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h6666, 1'b0);
        idle_step();
        idle_step();
        chk("pre_async_sys_rst", sys_rst, 1);
        reset_n = 1'b0;
        #1;
        chk("async_sys_rst", sys_rst, 0);
        chk("async_cause", viol_cause, 0);
        chk("async_cnt", viol_cnt, 0);
        chk("async_in_safe", in_safe_area, 0);
        model_reset();
        #1;
        reset_n = 1'b1;
        @(posedge mclk);
        #1;
        for (int i = 0; i < 20; i++) begin
            step(pick_ins(), pick_key(), ($urandom_range(0, 2) == 0),
                 pick_key(), ($urandom_range(0, 5) == 0), 16'($urandom), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/smart_access_sequencer.md
Name: smart_access_sequencer

Overview:
- Sequencing controller for the SMART protected-code / protected-key scheme.
- Tracks legal entry into and exit from the protected code region, checks key-region accesses from the CPU and DMA requesters, and arbitrates read data from the key region.
- On a violation it records the cause, counts the event, and drives a stretched system reset for a fixed number of cycles.
- Sits between the CPU/DMA memory buses and the key memory; its reset output feeds the system reset generator.

Parameters:
LOW_CODE, 16'hA000, first address of protected code; the only legal entry point.
HIGH_CODE, 16'hA0FF, last address of protected code (inclusive).
LOW_KEY, 16'h0200, first address of the key region.
HIGH_KEY, 16'h021F, last address of the key region (inclusive).
RST_CYCLES, 4, length of the sys_rst pulse in mclk cycles; legal range is 2 to 255.

Ports:
mclk  in  1  system clock; all state updates on its rising edge.
reset_n  in  1  asynchronous, active-low reset.
ins_addr  in  16  current instruction pointer.
cpu_addr  in  16  CPU data-bus address.
cpu_en  in  1  CPU data access strobe.
dma_addr  in  16  DMA address.
dma_en  in  1  DMA access strobe.
mem_din  in  16  key memory read data.
disable_debug  in  1  high suppresses violation detection.
cpu_dout  out  16  gated key read data to the CPU.
dma_dout  out  16  gated key read data to the DMA (always zero for key hits).
in_safe_area  out  1  high while executing inside the protected code.
sys_rst  out  1  high requests a system reset.
viol_cause  out  2  last violation cause: 0 = none, 1 = bad entry, 2 = CPU key access from outside, 3 = DMA key access.
viol_cnt  out  8  saturating count of violations.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE.
  - in_safe_area = 0, sys_rst = 0, viol_cause = 0, viol_cnt = 0, hold counter = 0.
- Definitions:
  - code_hit = LOW_CODE <= ins_addr <= HIGH_CODE.
  - entry = (ins_addr == LOW_CODE).
  - cpu_key = cpu_en & (LOW_KEY <= cpu_addr <= HIGH_KEY).
  - dma_key = dma_en & (LOW_KEY <= dma_addr <= HIGH_KEY).
  - Address comparisons are unsigned and inclusive at both ends.
- States: IDLE, INSIDE, VIOL, HOLD. in_safe_area = (state == INSIDE).
- IDLE transitions:
  - Violation, evaluated first:
    - dma_key gives cause 3.
    - Otherwise code_hit & ~entry gives cause 1.
    - Otherwise cpu_key & ~entry gives cause 2.
    - The next state is VIOL.
  - Else if entry, go to INSIDE next cycle.
  - A key access made in the entry cycle itself is legal.
- INSIDE transitions:
  - dma_key: cause 3, go to VIOL.
  - Else ~code_hit: go to IDLE. CPU key access in this exit cycle is judged as INSIDE, i.e. legal.
  - Re-hitting LOW_CODE while INSIDE is legal.
- VIOL (exactly 1 cycle):
  - sys_rst = 1.
  - viol_cause and viol_cnt were already updated on the edge entering VIOL.
  - Hold counter loads RST_CYCLES-2.
  - Next state is HOLD.
- HOLD:
  - sys_rst = 1.
  - Counter decrements each cycle; when the counter equals 0, go to IDLE.
  - The total sys_rst high time is exactly RST_CYCLES cycles.
  - New violations in HOLD are ignored: no count, no cause change.
- Recording:
  - viol_cnt increments on each entry to VIOL and saturates at 255.
  - viol_cause is sticky until the next violation or reset_n.
- disable_debug = 1:
  - Violation detection is off; the FSM never enters VIOL.
  - IDLE/INSIDE tracking continues, and data gating still applies.
  - Asserting it during HOLD does not shorten the pulse.
- Data gating (combinational):
  - cpu_dout = mem_din when cpu_key & (state == INSIDE | (state == IDLE & entry)), or when ~cpu_key & ~sys_rst; otherwise 0.
  - dma_dout = 0 when dma_key or sys_rst; otherwise mem_din.
- Latency:
  - State, status and sys_rst change one mclk edge after the triggering input.
  - Data gating has zero latency.

Test Plan:
- Legal entry and exit: ins_addr goes 16'h9FFE, then 16'hA000, then 16'hA010, then 16'hB000 -> in_safe_area is 0, then 1 the cycle after A000, then falls to 0 the cycle after B000; sys_rst stays 0.
- Bad entry: from IDLE, ins_addr = 16'hA004 -> after 1 edge sys_rst = 1 for exactly 4 cycles, viol_cause = 1, viol_cnt = 1, then IDLE.
- Key access rules:
  - Outside: cpu_en = 1 with cpu_addr = 16'h0210 and ins_addr = 16'h4000 -> cpu_dout = 0, viol_cause = 2.
  - Inside: the same access while INSIDE -> cpu_dout = mem_din (16'h5A5A), no violation.
- Simultaneous causes and HOLD masking:
  - In IDLE, dma_key together with ins_addr = 16'hA004 -> viol_cause = 3, not 1.
  - A further cpu_key during HOLD -> viol_cnt unchanged.
- Saturation and debug:
  - 260 violations -> viol_cnt = 255.
  - With disable_debug = 1, a bad entry -> sys_rst stays 0 and the count is unchanged.
- Asynchronous reset mid-HOLD: reset_n pulses low in the 2nd HOLD cycle -> sys_rst, viol_cause and viol_cnt clear immediately, without waiting for the mclk edge.
